// File: rtl/key_display_sched_pkg.sv
// Shared constants, key-state encoding and index helper for the key display scheduler.
package key_display_sched_pkg;

  localparam int NUM_KEYS = 7;
  localparam int KEY_W    = 3;
  localparam int PAD_W    = 1 << KEY_W;
  localparam int HOLD_MAX = 15;
  localparam int CNT_W    = 4;

  localparam logic [KEY_W-1:0] KEY_NONE = 3'd7;

  typedef enum logic [1:0] {
    KS_IDLE    = 2'd0,
    KS_PRESSED = 2'd1,
    KS_HOLD    = 2'd2
  } key_state_t;

  // Lowest set bit position of a key vector; 0 when the vector is empty.
  function automatic logic [KEY_W-1:0] lowest_index(input logic [NUM_KEYS-1:0] vec);
    logic [KEY_W-1:0] idx;
    idx = 3'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = KEY_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_display_sched_key_hold_fsm.sv
// One key's highlight FSM: tracks press, then stretches the highlight for a
// number of frames after release, counting only on frame boundaries.
module key_hold_fsm
  import key_display_sched_pkg::*;
#(
  parameter int HOLD_FRAMES = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic vsync_start,
  output logic active
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_FRAMES);
  localparam bit               NO_HOLD   = (HOLD_FRAMES == 0);

  key_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;

  // Key state, hold counter and registered active flag advance together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= KS_IDLE;
      cnt_r   <= 4'd0;
      active  <= 1'b0;
    end else begin
      case (state_r)
        KS_IDLE: begin
          if (req) begin
            state_r <= KS_PRESSED;
            active  <= 1'b1;
          end else begin
            state_r <= KS_IDLE;
            active  <= 1'b0;
          end
        end
        KS_PRESSED: begin
          // A release loads the full hold even on a frame boundary; the
          // first decrement waits for the following vsync_start.
          if (req) begin
            state_r <= KS_PRESSED;
            active  <= 1'b1;
          end else if (NO_HOLD) begin
            state_r <= KS_IDLE;
            cnt_r   <= 4'd0;
            active  <= 1'b0;
          end else begin
            state_r <= KS_HOLD;
            cnt_r   <= HOLD_LOAD;
            active  <= 1'b1;
          end
        end
        KS_HOLD: begin
          if (req) begin
            state_r <= KS_PRESSED;
            active  <= 1'b1;
          end else if (vsync_start) begin
            if (cnt_r == 4'd1) begin
              state_r <= KS_IDLE;
              cnt_r   <= 4'd0;
              active  <= 1'b0;
            end else begin
              cnt_r   <= cnt_r - 4'd1;
            end
          end else begin
            state_r <= KS_HOLD;
          end
        end
        default: begin
          state_r <= KS_IDLE;
          cnt_r   <= 4'd0;
          active  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_display_sched.sv
// Key highlight scheduler: per-key hold FSMs, frame-aligned display mask,
// one-cycle pixel pipeline to the colour stage and last-note tone arbiter.
module key_display_sched
  import key_display_sched_pkg::*;
#(
  parameter int HOLD_FRAMES = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_req,
  input  logic                vsync_start,
  input  logic [KEY_W-1:0]    pix_key,
  input  logic                pix_valid,
  output logic [KEY_W-1:0]    key_out,
  output logic                valid_out,
  output logic                down,
  output logic [NUM_KEYS-1:0] disp_mask,
  output logic                tone_en,
  output logic [KEY_W-1:0]    tone_key
);

  logic [NUM_KEYS-1:0] active_s;
  logic [NUM_KEYS-1:0] key_req_d_r;
  logic [NUM_KEYS-1:0] new_press_s;
  logic [PAD_W-1:0]    mask_pad_s;
  logic [PAD_W-1:0]    req_pad_s;
  logic                owner_valid_r;
  logic                owner_held_s;
  logic                down_next_s;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_hold_fsm #(
      .HOLD_FRAMES (HOLD_FRAMES)
    ) u_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (key_req[gi]),
      .vsync_start (vsync_start),
      .active      (active_s[gi])
    );
  end

  // Padded copies let a 3-bit key code index safely; code 7 reads a zero.
  always_comb begin
    mask_pad_s                = {PAD_W{1'b0}};
    mask_pad_s[NUM_KEYS-1:0]  = disp_mask;
    req_pad_s                 = {PAD_W{1'b0}};
    req_pad_s[NUM_KEYS-1:0]   = key_req;
    new_press_s               = key_req & ~key_req_d_r;
    owner_held_s              = owner_valid_r & req_pad_s[tone_key];
    if (pix_valid && (pix_key != KEY_NONE)) begin
      down_next_s = mask_pad_s[pix_key];
    end else begin
      down_next_s = 1'b0;
    end
  end

  // Commit the highlight mask only on frame boundaries so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_mask <= {NUM_KEYS{1'b0}};
    end else if (vsync_start) begin
      disp_mask <= active_s;
    end else begin
      disp_mask <= disp_mask;
    end
  end

  // Pixel pipeline: one fixed cycle of latency to the colour stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_out   <= KEY_NONE;
      valid_out <= 1'b0;
      down      <= 1'b0;
    end else begin
      key_out   <= pix_key;
      valid_out <= pix_valid;
      down      <= down_next_s;
    end
  end

  // Tone arbiter: newest press wins; on owner release fall back to the lowest held key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_req_d_r   <= {NUM_KEYS{1'b0}};
      tone_en       <= 1'b0;
      tone_key      <= 3'd0;
      owner_valid_r <= 1'b0;
    end else begin
      key_req_d_r <= key_req;
      if (new_press_s != {NUM_KEYS{1'b0}}) begin
        tone_key      <= lowest_index(new_press_s);
        tone_en       <= 1'b1;
        owner_valid_r <= 1'b1;
      end else if (!owner_held_s) begin
        if (key_req != {NUM_KEYS{1'b0}}) begin
          tone_key      <= lowest_index(key_req);
          tone_en       <= 1'b1;
          owner_valid_r <= 1'b1;
        end else begin
          tone_en       <= 1'b0;
          owner_valid_r <= 1'b0;
        end
      end else begin
        tone_en       <= tone_en;
        owner_valid_r <= owner_valid_r;
      end
    end
  end

endmodule

// File: tb/tb_key_display_sched.sv
// Bench for key_display_sched: table-driven pixel and tone vectors through
// scoreboard queues, plus hand-written hold, coincident-release and reset sequences.
module tb_key_display_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] key_req;
  logic       vsync_start;
  logic [2:0] pix_key;
  logic       pix_valid;

  logic [2:0] key_out,  key_out2;
  logic       valid_out, valid_out2;
  logic       down,     down2;
  logic [6:0] disp_mask, disp_mask2;
  logic       tone_en,  tone_en2;
  logic [2:0] tone_key, tone_key2;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [2:0] pk; logic pv; logic exp_down; } pix_vec_t;
  typedef struct { logic [6:0] req; logic exp_en; logic [2:0] exp_key; } tone_vec_t;
  typedef struct packed { logic [2:0] key; logic valid; logic down; } pix_exp_t;
  typedef struct packed { logic en; logic [2:0] key; } tone_exp_t;

  pix_exp_t  pix_q[$];
  tone_exp_t tone_q[$];
  pix_vec_t  pix_tab[6];
  tone_vec_t tone_tab[9];

  always #5 clk = ~clk;

  key_display_sched #(.HOLD_FRAMES(6)) dut (
    .clk(clk), .rst_n(rst_n), .key_req(key_req), .vsync_start(vsync_start),
    .pix_key(pix_key), .pix_valid(pix_valid), .key_out(key_out),
    .valid_out(valid_out), .down(down), .disp_mask(disp_mask),
    .tone_en(tone_en), .tone_key(tone_key)
  );

  key_display_sched #(.HOLD_FRAMES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .key_req(key_req), .vsync_start(vsync_start),
    .pix_key(pix_key), .pix_valid(pix_valid), .key_out(key_out2),
    .valid_out(valid_out2), .down(down2), .disp_mask(disp_mask2),
    .tone_en(tone_en2), .tone_key(tone_key2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    repeat (3) tick();
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
  endtask

  task automatic pix_step(input logic [2:0] pk, input logic pv, input logic exp_down);
    pix_exp_t e;
    pix_key   = pk;
    pix_valid = pv;
    pix_q.push_back({pk, pv, exp_down});
    tick();
    e = pix_q.pop_front();
    check("key_out",   32'(key_out),   32'(e.key));
    check("valid_out", 32'(valid_out), 32'(e.valid));
    check("down",      32'(down),      32'(e.down));
  endtask

  task automatic tone_step(input logic [6:0] req, input logic exp_en, input logic [2:0] exp_key);
    tone_exp_t e;
    key_req = req;
    tone_q.push_back({exp_en, exp_key});
    tick();
    e = tone_q.pop_front();
    check("tone_en",  32'(tone_en),  32'(e.en));
    check("tone_key", 32'(tone_key), 32'(e.key));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pix_tab[0] = '{3'd3, 1'b1, 1'b1};
    pix_tab[1] = '{3'd4, 1'b1, 1'b0};
    pix_tab[2] = '{3'd3, 1'b0, 1'b0};
    pix_tab[3] = '{3'd7, 1'b1, 1'b0};
    pix_tab[4] = '{3'd0, 1'b1, 1'b0};
    pix_tab[5] = '{3'd3, 1'b1, 1'b1};

    tone_tab[0] = '{7'h12, 1'b1, 3'd1};
    tone_tab[1] = '{7'h02, 1'b1, 3'd1};
    tone_tab[2] = '{7'h12, 1'b1, 3'd4};
    tone_tab[3] = '{7'h02, 1'b1, 3'd1};
    tone_tab[4] = '{7'h12, 1'b1, 3'd4};
    tone_tab[5] = '{7'h42, 1'b1, 3'd6};
    tone_tab[6] = '{7'h02, 1'b1, 3'd1};
    tone_tab[7] = '{7'h00, 1'b0, 3'd1};
    tone_tab[8] = '{7'h00, 1'b0, 3'd1};

    // Reset state, with a live pixel present so key_out's reset value is visible.
    rst_n       = 1'b0;
    key_req     = 7'h00;
    vsync_start = 1'b0;
    pix_key     = 3'd2;
    pix_valid   = 1'b1;
    repeat (3) tick();
    check("rst_disp_mask", 32'(disp_mask), 32'h0);
    check("rst_down",      32'(down),      32'h0);
    check("rst_valid_out", 32'(valid_out), 32'h0);
    check("rst_key_out",   32'(key_out),   32'h7);
    check("rst_tone_en",   32'(tone_en),   32'h0);
    check("rst_tone_key",  32'(tone_key),  32'h0);
    rst_n = 1'b1;
    pix_step(3'd2, 1'b1, 1'b0);
    check("post_rst_tone_en", 32'(tone_en), 32'h0);

    // Press key 3 mid-frame: mask waits for the next frame boundary.
    pix_key   = 3'd7;
    pix_valid = 1'b0;
    tone_step(7'h08, 1'b1, 3'd3);
    repeat (2) tick();
    check("press_midframe_mask", 32'(disp_mask), 32'h0);
    frame();
    check("press_commit_mask", 32'(disp_mask), 32'h08);
    for (int i = 0; i < 6; i++) begin
      pix_step(pix_tab[i].pk, pix_tab[i].pv, pix_tab[i].exp_down);
    end

    // Release key 3: highlight survives 6 boundaries, clears on the 7th.
    key_req = 7'h00;
    tick();
    for (int f = 1; f <= 7; f++) begin
      frame();
      check($sformatf("hold6_frame%0d", f), 32'(disp_mask[3]), (f <= 6) ? 32'h1 : 32'h0);
    end

    // Re-press during hold keeps the highlight with no gap.
    key_req = 7'h08;
    tick();
    frame();
    key_req = 7'h00;
    tick();
    for (int f = 1; f <= 2; f++) begin
      frame();
      check($sformatf("rehold_frame%0d", f), 32'(disp_mask[3]), 32'h1);
    end
    key_req = 7'h08;
    tick();
    for (int f = 1; f <= 8; f++) begin
      frame();
      check($sformatf("repress_frame%0d", f), 32'(disp_mask[3]), 32'h1);
    end
    key_req = 7'h00;
    tick();
    check("tone_off_after_release", 32'(tone_en), 32'h0);

    // Tone arbitration table.
    for (int i = 0; i < 9; i++) begin
      tone_step(tone_tab[i].req, tone_tab[i].exp_en, tone_tab[i].exp_key);
    end

    // Key 5 released on a vsync_start with HOLD_FRAMES=2.
    key_req = 7'h20;
    tick();
    frame();
    check("k5_commit_h2", 32'(disp_mask2[5]), 32'h1);
    repeat (2) tick();
    key_req     = 7'h00;
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    check("k5_coincident_h2", 32'(disp_mask2[5]), 32'h1);
    for (int f = 1; f <= 3; f++) begin
      frame();
      check($sformatf("k5_h2_frame%0d", f), 32'(disp_mask2[5]), (f <= 2) ? 32'h1 : 32'h0);
    end
    check("k5_h6_frame3", 32'(disp_mask[5]), 32'h1);

    // Reset in the middle of a hold with key 0 held.
    key_req = 7'h04;
    tick();
    key_req = 7'h01;
    tick();
    frame();
    check("pre_rst_mask_bits", 32'(disp_mask & 7'h05), 32'h05);
    rst_n = 1'b0;
    #1;
    check("async_rst_mask",     32'(disp_mask),  32'h0);
    check("async_rst_mask_h2",  32'(disp_mask2), 32'h0);
    check("async_rst_tone_en",  32'(tone_en),    32'h0);
    check("async_rst_tone_key", 32'(tone_key),   32'h0);
    check("async_rst_key_out",  32'(key_out),    32'h7);
    tick();
    rst_n = 1'b1;
    tone_step(7'h01, 1'b1, 3'd0);
    check("post_rst_mask_before_vsync", 32'(disp_mask), 32'h0);
    frame();
    check("post_rst_mask_after_vsync", 32'(disp_mask), 32'h01);
    pix_step(3'd0, 1'b1, 1'b1);
    pix_step(3'd2, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_display_sched.md
Name: key_display_sched

Overview:
Schedules the on-screen key highlighting and the shared single-voice tone generator for the 7-key piano.
- Takes per-key press levels from the keyboard decoder.
- Stretches each highlight to a minimum number of frames.
- Commits the display mask only at frame boundaries, so highlights never tear mid-frame.
- Drives the per-pixel down/key/valid inputs of the colour stage one cycle behind the pixel decoder.
- Arbitrates the single tone generator among the held keys.

Parameters:
NUM_KEYS, 7, number of keys; fixed at 7 while key codes are 3 bits.
HOLD_FRAMES, 6, frames a highlight persists after release (0..15).
KEY_W, 3, key code width; code 7 = no key.

Ports:
clk  in  1  system/pixel clock
rst_n  in  1  asynchronous active-low reset
key_req  in  NUM_KEYS  per-key held level, synchronous to clk, bit i = key i
vsync_start  in  1  one-cycle pulse at start of vertical blank
pix_key  in  KEY_W  key region of current pixel, 7 = outside keys
pix_valid  in  1  current pixel inside visible area
key_out  out  KEY_W  pix_key delayed 1 cycle, to colour stage
valid_out  out  1  pix_valid delayed 1 cycle, to colour stage
down  out  1  current pixel's key is highlighted, to colour stage
disp_mask  out  NUM_KEYS  committed highlight mask
tone_en  out  1  tone generator enabled
tone_key  out  KEY_W  key owning the tone generator

Behaviour:
- Reset values (async, rst_n low):
  - all key FSMs IDLE, hold counters 0
  - disp_mask 0, down 0, valid_out 0, key_out 7
  - tone_en 0, tone_key 0, owner-valid 0
- Per-key FSM, one per key; states IDLE, PRESSED, HOLD:
  - IDLE -> PRESSED when key_req[i]=1.
  - PRESSED -> HOLD when key_req[i]=0, loading counter with HOLD_FRAMES.
  - If HOLD_FRAMES=0, PRESSED -> IDLE directly on release.
  - HOLD -> PRESSED when key_req[i]=1; the counter is reloaded on the next release.
  - HOLD: counter decrements only on vsync_start. The vsync_start on which the counter is 1 moves the FSM to IDLE.
  - A release in the same cycle as vsync_start loads HOLD_FRAMES and does not decrement. The first decrement happens at the next vsync_start.
  - active[i] = (state != IDLE).
- Display commit:
  - disp_mask <= active on vsync_start only; otherwise disp_mask holds.
  - The active vector used is the one before the same-cycle FSM update.
  - A press is therefore visible from the frame after the next vsync_start.
  - Release to unhighlight takes exactly HOLD_FRAMES+1 commits (HOLD_FRAMES=6 -> 7th vsync_start after release).
- Pixel pipeline, latency exactly 1 cycle, no stalls:
  - key_out <= pix_key
  - valid_out <= pix_valid
  - down <= pix_valid & (pix_key != 7) & disp_mask[pix_key]
  - down uses the disp_mask value before any same-cycle commit.
- Tone arbiter (last-note priority), registered, 1-cycle latency from key_req:
  - new_press = key_req & ~key_req_d, where key_req_d is a 1-cycle delayed key_req.
  - If new_press != 0: owner <= lowest set index of new_press, tone_en <= 1.
  - Else if the owner's key_req is 0: owner <= lowest index with key_req=1, tone_en <= 1. If none, tone_en <= 0 and tone_key holds its last value.
  - Else hold.
  - Tone ignores HOLD state; the tone stops on release, not after the hold.
- Simultaneous press of key A and release of owner B in one cycle: A wins.
- Reset mid-frame or mid-hold clears everything. After reset, keys already held are treated as new presses on the first cycle (key_req_d resets to 0).

Decomposition:
- Shared package holds:
  - NUM_KEYS, KEY_W, KEY_NONE=3'd7
  - key FSM state encoding (IDLE=0, PRESSED=1, HOLD=2)
  - HOLD_FRAMES maximum and counter width (4)
- Sub-module key_hold_fsm (one key's FSM plus counter) is instantiated NUM_KEYS times with a generate loop.
- The arbiter, display commit and pixel pipeline stay in the top.

Test Plan:
- Reset with key_req=7'h00, then release rst_n -> all outputs at reset values; pix_key=2, pix_valid=1 gives down=0, key_out=2 one cycle later.
- key_req[3] rises mid-frame -> disp_mask stays 0 until the next vsync_start, then becomes 7'h08. pix_key=3 gives down=1; pix_key=4 gives down=0; pix_valid=0 gives down=0.
- key 3 released, HOLD_FRAMES=6 -> disp_mask[3] stays 1 through 6 vsync_starts and clears on the 7th. A re-press during hold keeps it set with no gap.
- key_req goes 7'h00 -> 7'h12 in one cycle -> tone_key=1, tone_en=1. Key 4 is then pressed alone -> tone_key=4. Key 4 is released -> tone_key=1. All keys released -> tone_en=0, tone_key stays 1.
- Release of key 5 coincident with vsync_start, HOLD_FRAMES=2 -> disp_mask[5] clears on the 3rd subsequent vsync_start, not earlier.
- rst_n asserted during HOLD with key_req[0] held -> all clear immediately. After release of reset, tone_key=0, tone_en=1 next cycle; disp_mask[0]=1 after the first vsync_start.
